// File: rtl/pwr_switch_emu_pkg.sv
// Shared types and constants for the power-switch emulator.
// Lane state encoding, ramp counter width and the saturating count adder.
package pwr_switch_emu_pkg;

    localparam int CNT_W = 8;
    localparam int ACC_W = 16;
    localparam int INC_W = 6;

    typedef enum logic [1:0] {
        LANE_ON       = 2'd0,
        LANE_RAMP_OFF = 2'd1,
        LANE_OFF      = 2'd2,
        LANE_RAMP_ON  = 2'd3
    } lane_state_e;

    // Adding up to 32 completions can carry out of 16 bits; clamp instead of wrapping.
    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] acc,
                                                 input logic [INC_W-1:0] inc);
        logic [ACC_W:0] sum;
        sum = {1'b0, acc} + {{(ACC_W+1-INC_W){1'b0}}, inc};
        return sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
    endfunction

endpackage

// File: rtl/pwr_switch_emu_lane.sv
// One emulated power switch: stable/ramp FSM with a down-counter for the latency.
// ack_n and busy are registered; done flags the cycle whose edge completes a ramp.
module pwr_switch_emu_lane
    import pwr_switch_emu_pkg::*;
#(
    parameter int ON_LATENCY  = 15,
    parameter int OFF_LATENCY = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic switch_n,
    input  logic hold,
    output logic ack_n,
    output logic busy,
    output logic done
);

    localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(ON_LATENCY - 1);
    localparam logic [CNT_W-1:0] OFF_LOAD = CNT_W'(OFF_LATENCY - 1);

    lane_state_e      state;
    lane_state_e      state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LANE_ON;
            cnt   <= '0;
            ack_n <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            ack_n <= (state_next == LANE_OFF) || (state_next == LANE_RAMP_ON);
            busy  <= (state_next == LANE_RAMP_OFF) || (state_next == LANE_RAMP_ON);
        end
    end

    // A reverted request beats both hold and completion: the lane falls back without toggling.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        done       = 1'b0;
        case (state)
            LANE_ON: begin
                if (switch_n) begin
                    state_next = LANE_RAMP_OFF;
                    cnt_next   = OFF_LOAD;
                end
            end
            LANE_OFF: begin
                if (!switch_n) begin
                    state_next = LANE_RAMP_ON;
                    cnt_next   = ON_LOAD;
                end
            end
            LANE_RAMP_OFF: begin
                if (!switch_n) begin
                    state_next = LANE_ON;
                    cnt_next   = '0;
                end else if (!hold) begin
                    if (cnt == '0) begin
                        state_next = LANE_OFF;
                        done       = 1'b1;
                    end else begin
                        cnt_next = cnt - CNT_W'(1);
                    end
                end
            end
            LANE_RAMP_ON: begin
                if (switch_n) begin
                    state_next = LANE_OFF;
                    cnt_next   = '0;
                end else if (!hold) begin
                    if (cnt == '0) begin
                        state_next = LANE_ON;
                        done       = 1'b1;
                    end else begin
                        cnt_next = cnt - CNT_W'(1);
                    end
                end
            end
            default: begin
                state_next = LANE_ON;
                cnt_next   = '0;
            end
        endcase
    end

endmodule

// File: rtl/pwr_switch_emu.sv
// Multi-domain power-switch emulator: one lane per domain plus a saturating
// count of completed acknowledge transitions across all domains.
module pwr_switch_emu
    import pwr_switch_emu_pkg::*;
#(
    parameter int NUM_DOMAINS = 3,
    parameter int ON_LATENCY  = 15,
    parameter int OFF_LATENCY = 15
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NUM_DOMAINS-1:0] switch_n_i,
    input  logic [NUM_DOMAINS-1:0] hold_i,
    output logic [NUM_DOMAINS-1:0] ack_n_o,
    output logic [NUM_DOMAINS-1:0] busy_o,
    output logic [ACC_W-1:0]       switch_cnt_o
);

    logic [NUM_DOMAINS-1:0] done;
    logic [INC_W-1:0]       done_sum;

    for (genvar g = 0; g < NUM_DOMAINS; g++) begin : g_lane
        pwr_switch_emu_lane #(
            .ON_LATENCY (ON_LATENCY),
            .OFF_LATENCY(OFF_LATENCY)
        ) u_lane (
            .clk     (clk_i),
            .rst_n   (rst_ni),
            .switch_n(switch_n_i[g]),
            .hold    (hold_i[g]),
            .ack_n   (ack_n_o[g]),
            .busy    (busy_o[g]),
            .done    (done[g])
        );
    end

    always_comb begin
        done_sum = '0;
        for (int i = 0; i < NUM_DOMAINS; i++) begin
            done_sum = done_sum + INC_W'(done[i]);
        end
    end

    // Counts land on the same edge as the ack toggles they correspond to.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            switch_cnt_o <= '0;
        end else begin
            switch_cnt_o <= sat_add(switch_cnt_o, done_sum);
        end
    end

endmodule

// File: tb/tb_pwr_switch_emu.sv
// Scoreboard bench for pwr_switch_emu: a default 3-domain instance and a
// 32-domain single-cycle-latency instance used for latency-1 and saturation.
`timescale 1ns/1ps
module tb_pwr_switch_emu;

    localparam int LAT = 15;

    typedef struct {
        int          due;
        logic [31:0] ack;
        logic [31:0] busy;
        logic [15:0] cnt;
    } exp_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [2:0]  sw1, hold1, ack1, busy1;
    logic [15:0] cnt1;
    logic [31:0] sw2, hold2, ack2, busy2;
    logic [15:0] cnt2;

    int   edge_cnt = 0;
    int   checks   = 0;
    int   errors   = 0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt++;

    pwr_switch_emu dut_std (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .switch_n_i  (sw1),
        .hold_i      (hold1),
        .ack_n_o     (ack1),
        .busy_o      (busy1),
        .switch_cnt_o(cnt1)
    );

    pwr_switch_emu #(
        .NUM_DOMAINS(32),
        .ON_LATENCY (1),
        .OFF_LATENCY(1)
    ) dut_fast (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .switch_n_i  (sw2),
        .hold_i      (hold2),
        .ack_n_o     (ack2),
        .busy_o      (busy2),
        .switch_cnt_o(cnt2)
    );

    task automatic test_reset();
        #2 rst_n = 1'b0;
        sw1 = 3'b111;
        sw2 = '1;
        #1;
        checks++; if (ack1 !== 3'b000)  begin errors++; $display("[TB] FAIL reset ack1: got %b want 000", ack1); end
        checks++; if (busy1 !== 3'b000) begin errors++; $display("[TB] FAIL reset busy1: got %b want 000", busy1); end
        checks++; if (cnt1 !== 16'h0)   begin errors++; $display("[TB] FAIL reset cnt1: got %h want 0000", cnt1); end
        checks++; if (cnt2 !== 16'h0)   begin errors++; $display("[TB] FAIL reset cnt2: got %h want 0000", cnt2); end
        repeat (3) @(negedge clk);
        checks++; if (ack1 !== 3'b000)  begin errors++; $display("[TB] FAIL reset_held ack1: got %b want 000", ack1); end
        checks++; if (busy2 !== 32'h0)  begin errors++; $display("[TB] FAIL reset_held busy2: got %h want 0", busy2); end
        sw1 = 3'b000;
        sw2 = '0;
        rst_n = 1'b1;
    endtask

    task automatic test_off_latency();
        exp_t e;
        int   r;
        int   guard = 0;
        @(negedge clk);
        sw1[1] = 1'b1;
        r = edge_cnt + 1;
        sb.push_back('{r,         32'h0, 32'h2, 16'd0});
        sb.push_back('{r+LAT-1,   32'h0, 32'h2, 16'd0});
        sb.push_back('{r+LAT,     32'h2, 32'h0, 16'd1});
        while (sb.size() > 0) begin
            @(negedge clk);
            if (sb[0].due == edge_cnt) begin
                e = sb.pop_front();
                checks++; if (ack1 !== e.ack[2:0])   begin errors++; $display("[TB] FAIL off_latency ack @%0d: got %b want %b", edge_cnt, ack1, e.ack[2:0]); end
                checks++; if (busy1 !== e.busy[2:0]) begin errors++; $display("[TB] FAIL off_latency busy @%0d: got %b want %b", edge_cnt, busy1, e.busy[2:0]); end
                checks++; if (cnt1 !== e.cnt)        begin errors++; $display("[TB] FAIL off_latency cnt @%0d: got %0d want %0d", edge_cnt, cnt1, e.cnt); end
            end
            if (++guard > 60) begin
                checks++; errors++;
                $display("[TB] FAIL off_latency timeout: got %0d pending want 0", sb.size());
                sb.delete();
            end
        end
    endtask

    task automatic test_latency_one();
        exp_t e;
        int   r;
        int   guard = 0;
        @(negedge clk);
        sw2[0] = 1'b1;
        r = edge_cnt + 1;
        sb.push_back('{r,   32'h0, 32'h1, 16'd0});
        sb.push_back('{r+1, 32'h1, 32'h0, 16'd1});
        sb.push_back('{r+5, 32'h1, 32'h1, 16'd1});
        sb.push_back('{r+6, 32'h0, 32'h0, 16'd2});
        while (sb.size() > 0) begin
            @(negedge clk);
            if (sb[0].due == edge_cnt) begin
                e = sb.pop_front();
                checks++; if (ack2 !== e.ack)   begin errors++; $display("[TB] FAIL latency_one ack @%0d: got %h want %h", edge_cnt, ack2, e.ack); end
                checks++; if (busy2 !== e.busy) begin errors++; $display("[TB] FAIL latency_one busy @%0d: got %h want %h", edge_cnt, busy2, e.busy); end
                checks++; if (cnt2 !== e.cnt)   begin errors++; $display("[TB] FAIL latency_one cnt @%0d: got %0d want %0d", edge_cnt, cnt2, e.cnt); end
            end
            if (edge_cnt == r + 4) sw2[0] = 1'b0;
            if (++guard > 30) begin
                checks++; errors++;
                $display("[TB] FAIL latency_one timeout: got %0d pending want 0", sb.size());
                sb.delete();
            end
        end
    endtask

    task automatic test_revert();
        exp_t e;
        int   r;
        int   guard = 0;
        @(negedge clk);
        sw1[2] = 1'b1;
        r = edge_cnt + 1;
        sb.push_back('{r+4,     32'h2, 32'h4, 16'd1});
        sb.push_back('{r+5,     32'h2, 32'h0, 16'd1});
        sb.push_back('{r+LAT+2, 32'h2, 32'h0, 16'd1});
        while (sb.size() > 0) begin
            @(negedge clk);
            if (sb[0].due == edge_cnt) begin
                e = sb.pop_front();
                checks++; if (ack1 !== e.ack[2:0])   begin errors++; $display("[TB] FAIL revert ack @%0d: got %b want %b", edge_cnt, ack1, e.ack[2:0]); end
                checks++; if (busy1 !== e.busy[2:0]) begin errors++; $display("[TB] FAIL revert busy @%0d: got %b want %b", edge_cnt, busy1, e.busy[2:0]); end
                checks++; if (cnt1 !== e.cnt)        begin errors++; $display("[TB] FAIL revert cnt @%0d: got %0d want %0d", edge_cnt, cnt1, e.cnt); end
            end
            // Hold is high when the revert is sampled; the revert must still win.
            if (edge_cnt == r + 2) hold1[2] = 1'b1;
            if (edge_cnt == r + 4) sw1[2]   = 1'b0;
            if (edge_cnt == r + 5) hold1[2] = 1'b0;
            if (++guard > 60) begin
                checks++; errors++;
                $display("[TB] FAIL revert timeout: got %0d pending want 0", sb.size());
                sb.delete();
            end
        end
    endtask

    task automatic test_hold();
        exp_t e;
        int   r;
        int   guard = 0;
        @(negedge clk);
        sw1[0] = 1'b1;
        r = edge_cnt + 1;
        sb.push_back('{r+LAT,   32'h2, 32'h1, 16'd1});
        sb.push_back('{r+LAT+6, 32'h2, 32'h1, 16'd1});
        sb.push_back('{r+LAT+7, 32'h3, 32'h0, 16'd2});
        while (sb.size() > 0) begin
            @(negedge clk);
            if (sb[0].due == edge_cnt) begin
                e = sb.pop_front();
                checks++; if (ack1 !== e.ack[2:0])   begin errors++; $display("[TB] FAIL hold ack @%0d: got %b want %b", edge_cnt, ack1, e.ack[2:0]); end
                checks++; if (busy1 !== e.busy[2:0]) begin errors++; $display("[TB] FAIL hold busy @%0d: got %b want %b", edge_cnt, busy1, e.busy[2:0]); end
                checks++; if (cnt1 !== e.cnt)        begin errors++; $display("[TB] FAIL hold cnt @%0d: got %0d want %0d", edge_cnt, cnt1, e.cnt); end
            end
            if (edge_cnt == r + 4)  hold1[0] = 1'b1;
            if (edge_cnt == r + 11) hold1[0] = 1'b0;
            if (++guard > 60) begin
                checks++; errors++;
                $display("[TB] FAIL hold timeout: got %0d pending want 0", sb.size());
                sb.delete();
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   r;
        int   guard = 0;
        // Hold on a stable lane must not stop it from starting its ramp.
        @(negedge clk);
        sw1      = 3'b000;
        hold1[0] = 1'b1;
        r = edge_cnt + 1;
        sb.push_back('{r,       32'h3, 32'h3, 16'd2});
        sb.push_back('{r+LAT-1, 32'h3, 32'h3, 16'd2});
        sb.push_back('{r+LAT,   32'h0, 32'h0, 16'd4});
        while (sb.size() > 0) begin
            @(negedge clk);
            if (sb[0].due == edge_cnt) begin
                e = sb.pop_front();
                checks++; if (ack1 !== e.ack[2:0])   begin errors++; $display("[TB] FAIL on_pair ack @%0d: got %b want %b", edge_cnt, ack1, e.ack[2:0]); end
                checks++; if (busy1 !== e.busy[2:0]) begin errors++; $display("[TB] FAIL on_pair busy @%0d: got %b want %b", edge_cnt, busy1, e.busy[2:0]); end
                checks++; if (cnt1 !== e.cnt)        begin errors++; $display("[TB] FAIL on_pair cnt @%0d: got %0d want %0d", edge_cnt, cnt1, e.cnt); end
            end
            if (edge_cnt == r) hold1[0] = 1'b0;
            if (++guard > 60) begin
                checks++; errors++;
                $display("[TB] FAIL on_pair timeout: got %0d pending want 0", sb.size());
                sb.delete();
            end
        end
        @(negedge clk);
        sw1 = 3'b111;
        r = edge_cnt + 1;
        guard = 0;
        sb.push_back('{r+LAT-1, 32'h0, 32'h7, 16'd4});
        sb.push_back('{r+LAT,   32'h7, 32'h0, 16'd7});
        while (sb.size() > 0) begin
            @(negedge clk);
            if (sb[0].due == edge_cnt) begin
                e = sb.pop_front();
                checks++; if (ack1 !== e.ack[2:0])   begin errors++; $display("[TB] FAIL all_off ack @%0d: got %b want %b", edge_cnt, ack1, e.ack[2:0]); end
                checks++; if (busy1 !== e.busy[2:0]) begin errors++; $display("[TB] FAIL all_off busy @%0d: got %b want %b", edge_cnt, busy1, e.busy[2:0]); end
                checks++; if (cnt1 !== e.cnt)        begin errors++; $display("[TB] FAIL all_off cnt @%0d: got %0d want %0d", edge_cnt, cnt1, e.cnt); end
            end
            if (++guard > 60) begin
                checks++; errors++;
                $display("[TB] FAIL all_off timeout: got %0d pending want 0", sb.size());
                sb.delete();
            end
        end
    endtask

    task automatic test_saturation();
        exp_t    e;
        int      r;
        longint  total;
        logic [15:0] want;
        @(negedge clk);
        // All 32 lanes complete every second edge, so the count climbs by 32 per pair.
        for (int k = 1; k <= 2050; k++) begin
            sw2 = ~sw2;
            r = edge_cnt + 1;
            if (k >= 2046) begin
                total = 64'd2 + 64'd32 * longint'(k);
                want  = (total > 64'd65535) ? 16'hFFFF : 16'(total);
                sb.push_back('{r+1, (k % 2 == 1) ? 32'hFFFF_FFFF : 32'h0, 32'h0, want});
            end
            @(negedge clk);
            @(negedge clk);
            if (sb.size() > 0 && sb[0].due == edge_cnt) begin
                e = sb.pop_front();
                checks++; if (ack2 !== e.ack)   begin errors++; $display("[TB] FAIL saturate ack k=%0d: got %h want %h", k, ack2, e.ack); end
                checks++; if (busy2 !== e.busy) begin errors++; $display("[TB] FAIL saturate busy k=%0d: got %h want %h", k, busy2, e.busy); end
                checks++; if (cnt2 !== e.cnt)   begin errors++; $display("[TB] FAIL saturate cnt k=%0d: got %h want %h", k, cnt2, e.cnt); end
            end
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL saturate pending: got %0d want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset_mid_ramp();
        exp_t e;
        int   r;
        int   guard = 0;
        @(negedge clk);
        sw1 = 3'b000;
        repeat (5) @(negedge clk);
        checks++; if (busy1 !== 3'b111) begin errors++; $display("[TB] FAIL mid_ramp busy: got %b want 111", busy1); end
        rst_n = 1'b0;
        sw1   = 3'b001;
        #1;
        checks++; if (ack1 !== 3'b000)  begin errors++; $display("[TB] FAIL abort ack1: got %b want 000", ack1); end
        checks++; if (busy1 !== 3'b000) begin errors++; $display("[TB] FAIL abort busy1: got %b want 000", busy1); end
        checks++; if (cnt1 !== 16'h0)   begin errors++; $display("[TB] FAIL abort cnt1: got %h want 0000", cnt1); end
        checks++; if (cnt2 !== 16'h0)   begin errors++; $display("[TB] FAIL abort cnt2: got %h want 0000", cnt2); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        r = edge_cnt + 1;
        sb.push_back('{r,       32'h0, 32'h1, 16'd0});
        sb.push_back('{r+LAT-1, 32'h0, 32'h1, 16'd0});
        sb.push_back('{r+LAT,   32'h1, 32'h0, 16'd1});
        while (sb.size() > 0) begin
            @(negedge clk);
            if (sb[0].due == edge_cnt) begin
                e = sb.pop_front();
                checks++; if (ack1 !== e.ack[2:0])   begin errors++; $display("[TB] FAIL post_reset ack @%0d: got %b want %b", edge_cnt, ack1, e.ack[2:0]); end
                checks++; if (busy1 !== e.busy[2:0]) begin errors++; $display("[TB] FAIL post_reset busy @%0d: got %b want %b", edge_cnt, busy1, e.busy[2:0]); end
                checks++; if (cnt1 !== e.cnt)        begin errors++; $display("[TB] FAIL post_reset cnt @%0d: got %0d want %0d", edge_cnt, cnt1, e.cnt); end
            end
            if (++guard > 60) begin
                checks++; errors++;
                $display("[TB] FAIL post_reset timeout: got %0d pending want 0", sb.size());
                sb.delete();
            end
        end
    endtask

    initial begin
        sw1   = 3'b000;
        hold1 = 3'b000;
        sw2   = '0;
        hold2 = '0;
        test_reset();
        test_off_latency();
        test_latency_one();
        test_revert();
        test_hold();
        test_back_to_back();
        test_saturation();
        test_reset_mid_ramp();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got time %0t want completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
